pc_sequencer: RTL and testbench

Owns the fetch program counter of the MIPS core and schedules the single shared 32-bit PC adder. In normal fetch the adder produces PC+4; on a taken branch it is reassigned for one cycle to compute branch base + shifted offset. The block also applies jump and exception redirects and drives the fetch handshake toward instruction memory. It sits between the decode/branch-resolution logic and the instruction-memory interface.

---
 rtl/pc_sequencer.sv | 122 ++++++++++++
 tb/tb_pc_sequencer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch program counter and scheduler for the one shared 32-bit PC adder.
// Optional macro PC_ALIGN_CHECK_EN traps misaligned redirect targets instead of truncating them.
module pc_sequencer #(
  parameter int          DATA_W     = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              imem_ready,
  input  logic              branch_req,
  input  logic              branch_taken,
  input  logic [DATA_W-1:0] branch_base,
  input  logic [DATA_W-1:0] branch_offset,
  input  logic              jump_req,
  input  logic [DATA_W-1:0] jump_target,
  input  logic              exc_req,
  output logic [DATA_W-1:0] pc,
  output logic              pc_valid,
  output logic              flush,
  output logic              pc_misalign
);

  typedef enum logic [1:0] {RST, FETCH, BRCALC} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] pc_nxt;
  logic              flush_nxt, misalign_nxt;
  logic [DATA_W-1:0] base_p0, off_p0;
  logic              capture;
  logic [DATA_W-1:0] add_a, add_b, add_sum;
  logic              target_bad;
  logic [DATA_W-1:0] target_sel, target_pc;

  function automatic logic [DATA_W-1:0] align_target(input logic [DATA_W-1:0] t);
    return {t[DATA_W-1:2], 2'b00};
  endfunction

  // Single adder; BRCALC borrows it for the branch target, otherwise PC+4
  always_comb begin
    add_a   = (state == BRCALC) ? base_p0 : pc;
    add_b   = (state == BRCALC) ? off_p0 : DATA_W'(4);
    add_sum = add_a + add_b;
  end

  assign target_sel = (state == BRCALC) ? add_sum : jump_target;

`ifdef PC_ALIGN_CHECK_EN
  assign target_bad = (target_sel[1:0] != 2'b00);
  assign target_pc  = target_bad ? EXC_VECTOR : target_sel;
`else
  assign target_bad = 1'b0;
  assign target_pc  = align_target(target_sel);
`endif

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    flush_nxt    = 1'b0;
    misalign_nxt = 1'b0;
    capture      = 1'b0;
    unique case (state)
      RST: begin
        state_nxt = FETCH;
      end
      FETCH: begin
        if (exc_req) begin
          pc_nxt    = EXC_VECTOR;
          flush_nxt = 1'b1;
        end else if (jump_req) begin
          pc_nxt       = target_pc;
          flush_nxt    = 1'b1;
          misalign_nxt = target_bad;
        end else if (branch_req && branch_taken) begin
          capture   = 1'b1;
          state_nxt = BRCALC;
        end else if (pc_valid && imem_ready && !stall) begin
          pc_nxt = add_sum;
        end
      end
      BRCALC: begin
        state_nxt = FETCH;
        flush_nxt = 1'b1;
        if (exc_req) begin
          pc_nxt = EXC_VECTOR;
        end else begin
          pc_nxt       = target_pc;
          misalign_nxt = target_bad;
        end
      end
      default: begin
        state_nxt = RST;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RST;
      pc          <= RESET_PC;
      pc_valid    <= 1'b0;
      flush       <= 1'b0;
      pc_misalign <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      pc_valid    <= (state_nxt == FETCH);
      flush       <= flush_nxt;
      pc_misalign <= misalign_nxt;
    end
  end

  // Branch operands are pure data; a reset returns to RST, which never reads them
  always_ff @(posedge clock) begin
    if (capture) begin
      base_p0 <= branch_base;
      off_p0  <= branch_offset;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, handshake, branch, priority, wrap, abort, alignment.
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        stall, imem_ready;
  logic        branch_req, branch_taken;
  logic [31:0] branch_base, branch_offset;
  logic        jump_req;
  logic [31:0] jump_target;
  logic        exc_req;
  logic [31:0] pc;
  logic        pc_valid, flush, pc_misalign;

  int errors = 0;
  int checks = 0;

  pc_sequencer dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .stall        (stall),
    .imem_ready   (imem_ready),
    .branch_req   (branch_req),
    .branch_taken (branch_taken),
    .branch_base  (branch_base),
    .branch_offset(branch_offset),
    .jump_req     (jump_req),
    .jump_target  (jump_target),
    .exc_req      (exc_req),
    .pc           (pc),
    .pc_valid     (pc_valid),
    .flush        (flush),
    .pc_misalign  (pc_misalign)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] epc, input logic ev,
                         input logic ef, input logic em);
    check({tag, ".pc"}, pc, epc);
    check({tag, ".valid"}, {31'b0, pc_valid}, {31'b0, ev});
    check({tag, ".flush"}, {31'b0, flush}, {31'b0, ef});
    check({tag, ".misalign"}, {31'b0, pc_misalign}, {31'b0, em});
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; imem_ready = 1'b1;
    branch_req = 1'b0; branch_taken = 1'b0; branch_base = '0; branch_offset = '0;
    jump_req = 1'b0; jump_target = '0; exc_req = 1'b0;
    tick(); tick();
    chk_all("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    #1;
    chk_all("release", 32'h0, 1'b0, 1'b0, 1'b0);
    tick(); chk_all("adv0", 32'h0, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("adv4", 32'h4, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("adv8", 32'h8, 1'b1, 1'b0, 1'b0);

    // Stall then backpressure
    stall = 1'b1;
    tick(); check("stall1", pc, 32'h8);
    tick(); check("stall2", pc, 32'h8);
    tick(); check("stall3", pc, 32'h8);
    stall = 1'b0; imem_ready = 1'b0;
    tick(); check("bp1", pc, 32'h8);
    tick(); check("bp2", pc, 32'h8);
    imem_ready = 1'b1;
    tick(); chk_all("resume", 32'hC, 1'b1, 1'b0, 1'b0);

    // Branch not taken behaves like a plain advance
    branch_req = 1'b1; branch_taken = 1'b0; branch_base = 32'h500; branch_offset = 32'h40;
    tick(); chk_all("bnt", 32'h10, 1'b1, 1'b0, 1'b0);

    // Taken branch with negative offset, stall asserted during BRCALC
    branch_taken = 1'b1; branch_base = 32'h100; branch_offset = 32'hFFFF_FFF0;
    tick(); chk_all("brcalc", 32'h10, 1'b0, 1'b0, 1'b0);
    branch_req = 1'b0; branch_taken = 1'b0; stall = 1'b1;
    tick(); chk_all("brtgt", 32'hF0, 1'b1, 1'b1, 1'b0);
    stall = 1'b0;
    tick(); chk_all("brnext", 32'hF4, 1'b1, 1'b0, 1'b0);

    // All three redirects at once: exception wins, no BRCALC cycle
    exc_req = 1'b1; jump_req = 1'b1; jump_target = 32'h400;
    branch_req = 1'b1; branch_taken = 1'b1; branch_base = 32'h300; branch_offset = 32'h8;
    tick(); chk_all("prio", 32'h80, 1'b1, 1'b1, 1'b0);
    exc_req = 1'b0; jump_req = 1'b0; branch_req = 1'b0; branch_taken = 1'b0;
    tick(); chk_all("prio_next", 32'h84, 1'b1, 1'b0, 1'b0);

    // Jump to the top of the address space, then wrap
    jump_req = 1'b1; jump_target = 32'hFFFF_FFFC;
    tick(); chk_all("jtop", 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0);
    jump_req = 1'b0;
    tick(); chk_all("wrap", 32'h0, 1'b1, 1'b0, 1'b0);

    // Exception aborts a branch calculation
    branch_req = 1'b1; branch_taken = 1'b1; branch_base = 32'h1000; branch_offset = 32'h20;
    tick(); chk_all("abort_calc", 32'h0, 1'b0, 1'b0, 1'b0);
    branch_req = 1'b0; branch_taken = 1'b0; exc_req = 1'b1;
    tick(); chk_all("abort", 32'h80, 1'b1, 1'b1, 1'b0);
    exc_req = 1'b0;
    tick(); chk_all("abort_next", 32'h84, 1'b1, 1'b0, 1'b0);

    // Branch target overflow wraps silently
    branch_req = 1'b1; branch_taken = 1'b1; branch_base = 32'hFFFF_FFF0; branch_offset = 32'h20;
    tick(); check("bwrap_calc", {31'b0, pc_valid}, 32'h0);
    branch_req = 1'b0; branch_taken = 1'b0;
    tick(); chk_all("bwrap", 32'h10, 1'b1, 1'b1, 1'b0);

    // Misaligned jump target
    jump_req = 1'b1; jump_target = 32'h202;
    tick();
`ifdef PC_ALIGN_CHECK_EN
    chk_all("misjump", 32'h80, 1'b1, 1'b1, 1'b1);
    jump_req = 1'b0;
    tick(); chk_all("misjump_next", 32'h84, 1'b1, 1'b0, 1'b0);
`else
    chk_all("misjump", 32'h200, 1'b1, 1'b1, 1'b0);
    jump_req = 1'b0;
    tick(); chk_all("misjump_next", 32'h204, 1'b1, 1'b0, 1'b0);
`endif

    // Reset asserted mid-BRCALC takes effect without a clock edge
    branch_req = 1'b1; branch_taken = 1'b1; branch_base = 32'h700; branch_offset = 32'h10;
    tick(); check("rst_calc", {31'b0, pc_valid}, 32'h0);
    branch_req = 1'b0; branch_taken = 1'b0;
    reset_n = 1'b0;
    #1;
    chk_all("rst_mid", 32'h0, 1'b0, 1'b0, 1'b0);
    tick(); chk_all("rst_hold", 32'h0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    tick(); chk_all("rst_fetch", 32'h0, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("rst_adv", 32'h4, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
